pipe_stage_skid: RTL and testbench

Parametrised pipeline-stage register, the successor to the fixed-width inter-stage latches between EX/MEM/WB. It moves a control word and a data word from one stage to the next under a valid/ready handshake and supports back-pressure (stall) and flush (bubble insertion). An optional second skid entry keeps the upstream `in_ready_o` a pure flop output, which breaks the combinational ready path across stages. It sits between any two pipeline stages; one instance is used per boundary.

---
 rtl/pipe_pkg.sv | 12 +
 rtl/pipe_stage_skid_if.sv | 28 ++
 rtl/pipe_slot.sv | 22 ++
 rtl/pipe_stage_skid.sv | 92 +++++++++
 tb/tb_pipe_stage_skid.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared definitions for the inter-stage pipeline register.
//   PIPE_DATA_W / PIPE_CTRL_W : default payload widths
//   PS_EMPTY / PS_BUSY / PS_FULL : stage state encoding (also the occupancy)
package pipe_pkg;
   localparam int PIPE_DATA_W = 64;
   localparam int PIPE_CTRL_W = 8;

   // Encoding doubles as the held-entry count driven on level_o.
   localparam logic [1:0] PS_EMPTY = 2'd0;
   localparam logic [1:0] PS_BUSY  = 2'd1;
   localparam logic [1:0] PS_FULL  = 2'd2;
endpackage

// File: rtl/pipe_stage_skid_if.sv
// pipe_stage_skid_if: handshake bundle of one pipeline boundary.
//   upstream   : flush_i, in_valid_i, in_ready_o, in_ctrl_i, in_data_i
//   downstream : out_valid_o, out_ready_i, out_ctrl_o, out_data_o, level_o
//   master = the environment driving the stage, slave = the stage itself.
interface pipe_stage_skid_if import pipe_pkg::*; #(
   parameter int DATA_W = PIPE_DATA_W,
   parameter int CTRL_W = PIPE_CTRL_W
);
   logic              flush_i;
   logic              in_valid_i;
   logic              in_ready_o;
   logic [CTRL_W-1:0] in_ctrl_i;
   logic [DATA_W-1:0] in_data_i;
   logic              out_valid_o;
   logic              out_ready_i;
   logic [CTRL_W-1:0] out_ctrl_o;
   logic [DATA_W-1:0] out_data_o;
   logic [1:0]        level_o;

   modport master (
      output flush_i, in_valid_i, in_ctrl_i, in_data_i, out_ready_i,
      input  in_ready_o, out_valid_o, out_ctrl_o, out_data_o, level_o
   );
   modport slave (
      input  flush_i, in_valid_i, in_ctrl_i, in_data_i, out_ready_i,
      output in_ready_o, out_valid_o, out_ctrl_o, out_data_o, level_o
   );
endinterface

// File: rtl/pipe_slot.sv
// pipe_slot: one storage entry (control + data word) of a pipeline stage.
//   clk, rst_n : clock, async active-low clear
//   ld_i, d_i  : load enable and word to load
//   q_o        : held word
module pipe_slot #(
   parameter int W = 72
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         ld_i,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);
   logic [W-1:0] slot_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    slot_q <= '0;
      else if (ld_i) slot_q <= d_i;
   end

   assign q_o = slot_q;
endmodule

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: valid/ready pipeline register between two stages with
// stall, flush and an optional skid entry.
//   clk, rst : clock, async active-low reset
//   bus      : slave side of pipe_stage_skid_if (handshakes, payload, level)
// SKID_EN=1 gives two entries and an in_ready_o decoded only from state
// flops; SKID_EN=0 gives a single stall-able register with combinational
// ready.
module pipe_stage_skid import pipe_pkg::*; #(
   parameter int DATA_W  = PIPE_DATA_W,
   parameter int CTRL_W  = PIPE_CTRL_W,
   parameter bit SKID_EN = 1'b1
) (
   input  logic               clk,
   input  logic               rst,
   pipe_stage_skid_if.slave   bus
);
   localparam int W = DATA_W + CTRL_W;

   logic [1:0]   state_q, state_d;
   logic         in_hs, out_hs, in_ready, out_valid;
   logic         main_ld, skid_ld;
   logic [W-1:0] in_word, main_d, main_q, skid_q;

   assign out_valid = (state_q != PS_EMPTY);
   // Skid mode: no path from out_ready_i, which breaks the ready chain.
   assign in_ready  = SKID_EN ? (state_q != PS_FULL)
                              : (!out_valid | bus.out_ready_i);
   assign in_hs     = bus.in_valid_i & in_ready;
   assign out_hs    = out_valid & bus.out_ready_i;
   assign in_word   = {bus.in_ctrl_i, bus.in_data_i};

   always_comb begin
      state_d = state_q;
      main_ld = 1'b0;
      skid_ld = 1'b0;
      case (state_q)
         PS_EMPTY: if (in_hs) begin
            main_ld = 1'b1;
            state_d = PS_BUSY;
         end
         PS_BUSY: begin
            if (in_hs && out_hs) begin
               main_ld = 1'b1;
            end else if (in_hs && SKID_EN) begin
               skid_ld = 1'b1;
               state_d = PS_FULL;
            end else if (out_hs) begin
               state_d = PS_EMPTY;
            end
         end
         PS_FULL: if (out_hs) begin
            main_ld = 1'b1;       // skid entry advances to the head
            state_d = PS_BUSY;
         end
         default: state_d = PS_EMPTY;
      endcase
      // Flush wins over both handshakes; slots keep their stale words.
      if (bus.flush_i) begin
         state_d = PS_EMPTY;
         main_ld = 1'b0;
         skid_ld = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= PS_EMPTY;
      else      state_q <= state_d;
   end

   // Only FULL refills the head from the skid entry; otherwise from input.
   assign main_d = (state_q == PS_FULL) ? skid_q : in_word;

   pipe_slot #(.W(W)) u_main (
      .clk(clk), .rst_n(rst), .ld_i(main_ld), .d_i(main_d), .q_o(main_q)
   );

   generate
      if (SKID_EN) begin : g_skid
         pipe_slot #(.W(W)) u_skid (
            .clk(clk), .rst_n(rst), .ld_i(skid_ld), .d_i(in_word), .q_o(skid_q)
         );
      end else begin : g_noskid
         assign skid_q = '0;
      end
   endgenerate

   assign bus.in_ready_o  = in_ready;
   assign bus.out_valid_o = out_valid;
   assign bus.out_ctrl_o  = out_valid ? main_q[W-1 -: CTRL_W] : '0;
   assign bus.out_data_o  = main_q[DATA_W-1:0];
   assign bus.level_o     = state_q;
endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench: channel 0 is a SKID_EN=1 stage, channel 1 a SKID_EN=0 stage.
// A negedge monitor scores every accepted word against what leaves.
module tb_pipe_stage_skid;
   typedef struct packed {logic [7:0] c; logic [63:0] d;} word_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic       fl[2], iv[2], ordy[2];
   word_t      iw[2];
   logic       ir[2], ov[2];
   logic [7:0] oc[2];
   logic [63:0] od[2];
   logic [1:0] lv[2];

   word_t sbq[2][$];
   int n_vec = 0;
   int n_err = 0;

   pipe_stage_skid_if #(.DATA_W(64), .CTRL_W(8)) bs();
   pipe_stage_skid_if #(.DATA_W(64), .CTRL_W(8)) bc();

   pipe_stage_skid #(.DATA_W(64), .CTRL_W(8), .SKID_EN(1'b1)) u_skid (
      .clk(clk), .rst(rst), .bus(bs.slave));
   pipe_stage_skid #(.DATA_W(64), .CTRL_W(8), .SKID_EN(1'b0)) u_comb (
      .clk(clk), .rst(rst), .bus(bc.slave));

   assign bs.flush_i = fl[0];   assign bc.flush_i = fl[1];
   assign bs.in_valid_i = iv[0]; assign bc.in_valid_i = iv[1];
   assign bs.in_ctrl_i = iw[0].c; assign bc.in_ctrl_i = iw[1].c;
   assign bs.in_data_i = iw[0].d; assign bc.in_data_i = iw[1].d;
   assign bs.out_ready_i = ordy[0]; assign bc.out_ready_i = ordy[1];
   assign ir[0] = bs.in_ready_o;  assign ir[1] = bc.in_ready_o;
   assign ov[0] = bs.out_valid_o; assign ov[1] = bc.out_valid_o;
   assign oc[0] = bs.out_ctrl_o;  assign oc[1] = bc.out_ctrl_o;
   assign od[0] = bs.out_data_o;  assign od[1] = bc.out_data_o;
   assign lv[0] = bs.level_o;     assign lv[1] = bc.level_o;

   task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk); #1;
   endtask

   // Scoreboard monitor: pop/compare on output handshake, push on input
   // handshake, drop everything on flush or reset.
   initial forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         if (!rst) begin
            sbq[i].delete();
         end else begin
            chk($sformatf("ch%0d level", i), 72'(lv[i]), 72'(sbq[i].size()));
            if (!ov[i]) chk($sformatf("ch%0d ctrl_mask", i), 72'(oc[i]), 72'd0);
            if (ov[i] && ordy[i]) begin
               if (sbq[i].size() == 0) begin
                  chk($sformatf("ch%0d unexpected_out", i), {oc[i], od[i]}, 72'h0);
                  n_vec--;
                  if ({oc[i], od[i]} == 72'h0) begin n_vec++; n_err++;
                     $display("FAIL ch%0d unexpected_out: got 0 expected none", i); end
               end else begin
                  word_t e;
                  e = sbq[i].pop_front();
                  chk($sformatf("ch%0d out_word", i), {oc[i], od[i]}, e);
               end
            end
            if (fl[i]) sbq[i].delete();
            else if (iv[i] && ir[i]) sbq[i].push_back(iw[i]);
         end
      end
   end

   task automatic idle_all;
      for (int i = 0; i < 2; i++) begin
         fl[i] = 1'b0; iv[i] = 1'b0; ordy[i] = 1'b1; iw[i] = '0;
      end
   endtask

   task automatic chk_reset(input int i, input string nm);
      chk({nm, " valid"}, 72'(ov[i]), 72'd0);
      chk({nm, " ctrl"}, 72'(oc[i]), 72'd0);
      chk({nm, " data"}, 72'(od[i]), 72'd0);
      chk({nm, " level"}, 72'(lv[i]), 72'd0);
      chk({nm, " in_ready"}, 72'(ir[i]), 72'd1);
   endtask

   initial begin
      idle_all();
      rst = 1'b1;
      #1 rst = 1'b0;
      tick(); tick();
      chk_reset(0, "rst0"); chk_reset(1, "rst1");
      rst = 1'b1;
      tick();

      // Stream 0x10..0x12 back to back on both stages
      for (int i = 0; i < 2; i++) begin iv[i] = 1'b1; iw[i] = '{8'h01, 64'h10}; end
      tick();
      for (int i = 0; i < 2; i++) iw[i] = '{8'h02, 64'h11};
      #1 for (int i = 0; i < 2; i++) begin chk("stream 10", od[i], 72'h10); chk("stream lvl", 72'(lv[i]), 72'd1); end
      tick();
      for (int i = 0; i < 2; i++) iw[i] = '{8'h03, 64'h12};
      #1 for (int i = 0; i < 2; i++) begin chk("stream 11", od[i], 72'h11); chk("stream lvl", 72'(lv[i]), 72'd1); end
      tick();
      for (int i = 0; i < 2; i++) iv[i] = 1'b0;
      #1 for (int i = 0; i < 2; i++) begin chk("stream 12", od[i], 72'h12); chk("stream lvl", 72'(lv[i]), 72'd1); end
      tick();
      for (int i = 0; i < 2; i++) chk("stream drained", 72'(lv[i]), 72'd0);

      // Skid fill on channel 0
      ordy[0] = 1'b0; iv[0] = 1'b1; iw[0] = '{8'h0A, 64'hA0};
      tick();
      iw[0] = '{8'h0B, 64'hA1};
      #1 chk("skid rdy_busy", 72'(ir[0]), 72'd1);
      tick();
      iv[0] = 1'b0;
      #1 chk("skid level", 72'(lv[0]), 72'd2);
      chk("skid in_ready", 72'(ir[0]), 72'd0);
      chk("skid head", od[0], 72'hA0);
      ordy[0] = 1'b1;
      #1 chk("skid out A0", od[0], 72'hA0);
      tick();
      chk("skid out A1", od[0], 72'hA1);
      chk("skid lvl1", 72'(lv[0]), 72'd1);
      tick();
      chk("skid empty", 72'(lv[0]), 72'd0);

      // Combinational-ready mode on channel 1
      ordy[1] = 1'b0; iv[1] = 1'b1; iw[1] = '{8'h0C, 64'hB0};
      tick();
      iw[1] = '{8'h0D, 64'hB1};
      #1 chk("comb stall rdy", 72'(ir[1]), 72'd0);
      ordy[1] = 1'b1;
      #1 chk("comb same-cycle rdy", 72'(ir[1]), 72'd1);
      tick();
      iv[1] = 1'b0;
      #1 chk("comb replaced", od[1], 72'hB1);
      tick();

      // Flush in FULL with input offered (ctrl 0xFF never appears)
      ordy[0] = 1'b0; iv[0] = 1'b1; iw[0] = '{8'h11, 64'hC0};
      tick();
      iw[0] = '{8'h12, 64'hC1};
      tick();
      fl[0] = 1'b1; iw[0] = '{8'hFF, 64'hFF};
      tick();
      fl[0] = 1'b0; iv[0] = 1'b0;
      #1 chk("flush valid", 72'(ov[0]), 72'd0);
      chk("flush ctrl", 72'(oc[0]), 72'd0);
      chk("flush level", 72'(lv[0]), 72'd0);
      chk("flush in_ready", 72'(ir[0]), 72'd1);
      chk("flush data held", od[0], 72'hC0);

      // Flush in BUSY while an input actually handshakes: it is dropped
      iv[0] = 1'b1; iw[0] = '{8'h13, 64'hE0};
      tick();
      fl[0] = 1'b1; iw[0] = '{8'hFF, 64'hFF};
      tick();
      fl[0] = 1'b0; iv[0] = 1'b0;
      #1 chk("flush2 valid", 72'(ov[0]), 72'd0);
      chk("flush2 data", od[0], 72'hE0);
      ordy[0] = 1'b1;
      tick(); tick();

      // Async reset while FULL, between clock edges
      ordy[0] = 1'b0; iv[0] = 1'b1; iw[0] = '{8'h21, 64'hD0};
      tick();
      iw[0] = '{8'h22, 64'hD1};
      tick();
      iv[0] = 1'b0;
      #2 rst = 1'b0;
      #1 chk_reset(0, "async");
      tick();
      rst = 1'b1; ordy[0] = 1'b1;
      tick();

      // Random back-pressure on both stages
      for (int n = 0; n < 1000; n++) begin
         for (int i = 0; i < 2; i++) begin
            iv[i] = 1'($urandom_range(0, 1));
            ordy[i] = ($urandom_range(0, 3) != 0);
            iw[i] = {8'($urandom), $urandom, $urandom};
         end
         tick();
      end
      idle_all();
      repeat (5) tick();
      for (int i = 0; i < 2; i++) chk("drain", 72'(sbq[i].size()), 72'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
